// File: rtl/alu_issue_scheduler.sv
// Shares one static-latency ALU between two valid/ready requesters, round-robin.
// Latency: rsp_valid L(op)+1 cycles after accept (L = ADDER_STAGES or MULT_STAGES).
// Backpressure: reqN_ready drops when the op's writeback slot is taken or the other side wins.
module alu_issue_scheduler #(
    parameter int ADDER_STAGES = 2,
    parameter int MULT_STAGES  = 3,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    output logic [1:0]       alu_operation,
    input  logic [31:0]      alu_result,
    input  logic             alu_exception,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             busy
);
    localparam int MAX_LAT = ((ADDER_STAGES > MULT_STAGES) ? ADDER_STAGES : MULT_STAGES) + 1;
    localparam int LW = $clog2(MAX_LAT);
    localparam logic [LW-1:0] ADD_LAT = LW'(ADDER_STAGES);
    localparam logic [LW-1:0] MUL_LAT = LW'(MULT_STAGES);
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } slot_t;

    logic [MAX_LAT-1:0] res, res_shift, res_next;
    slot_t              tag_pipe [MAX_LAT];
    logic               rr_ptr;
    logic [LW-1:0]      lat0, lat1, g_lat;
    logic               elig0, elig1, grant0, grant1, grant;
    logic [1:0]         g_op;
    logic [31:0]        g_a, g_b;
    slot_t              g_slot;

    // Eligibility looks at the reservation vector as it will be after this edge's shift.
    always_comb begin
        res_shift  = res >> 1;
        lat0       = (req0_op == OP_MUL) ? MUL_LAT : ADD_LAT;
        lat1       = (req1_op == OP_MUL) ? MUL_LAT : ADD_LAT;
        elig0      = req0_valid && !res_shift[lat0];
        elig1      = req1_valid && !res_shift[lat1];
        grant0     = elig0 && (!elig1 || !rr_ptr);
        grant1     = elig1 && (!elig0 || rr_ptr);
        grant      = grant0 || grant1;
        g_op       = grant1 ? req1_op : req0_op;
        g_a        = grant1 ? req1_a  : req0_a;
        g_b        = grant1 ? req1_b  : req0_b;
        g_lat      = grant1 ? lat1    : lat0;
        g_slot.id  = grant1;
        g_slot.tag = grant1 ? req1_tag : req0_tag;
        g_slot.ill = (g_op == OP_ILL);
        res_next   = res_shift;
        if (grant) begin
            res_next[g_lat] = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = |res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res           <= '0;
            rr_ptr        <= 1'b0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_operation <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_tag       <= '0;
            rsp_result    <= '0;
            rsp_flags     <= '0;
            for (int i = 0; i < MAX_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            res <= res_next;
            for (int i = 0; i < MAX_LAT - 1; i++) begin
                tag_pipe[i] <= tag_pipe[i+1];
            end
            tag_pipe[MAX_LAT-1] <= '0;
            if (grant) begin
                tag_pipe[g_lat] <= g_slot;
                rr_ptr          <= grant0;
                // Illegal ops occupy a slot but leave the ALU inputs untouched.
                if (g_op != OP_ILL) begin
                    alu_operand_a <= g_a;
                    alu_operand_b <= g_b;
                    alu_operation <= g_op;
                end
            end
            rsp_valid <= res[0];
            if (res[0]) begin
                rsp_id     <= tag_pipe[0].id;
                rsp_tag    <= tag_pipe[0].tag;
                rsp_result <= tag_pipe[0].ill ? 32'd0 : alu_result;
                rsp_flags  <= tag_pipe[0].ill ? 3'b100
                                              : {alu_exception, alu_overflow, alu_underflow};
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with a small static-latency ALU model.
module tb_alu_issue_scheduler;
    localparam int AS = 2;
    localparam int MS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_tag = 0, req1_tag = 0;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result;
    logic [1:0]  alu_operation;
    logic        alu_exception, alu_overflow, alu_underflow;
    logic        rsp_valid, rsp_id, busy;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;

    alu_issue_scheduler #(.ADDER_STAGES(AS), .MULT_STAGES(MS), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_operation(alu_operation), .alu_result(alu_result),
        .alu_exception(alu_exception), .alu_overflow(alu_overflow),
        .alu_underflow(alu_underflow),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: {exception, overflow, underflow, result} from a table of known vectors.
    function automatic logic [34:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [65:0] key;
        key = {op, a, b};
        case (key)
            {2'd0, 32'h3f800000, 32'h40000000}: alu_f = {3'b000, 32'h40400000};
            {2'd0, 32'h40000000, 32'h40000000}: alu_f = {3'b000, 32'h40800000};
            {2'd0, 32'h40400000, 32'h3f800000}: alu_f = {3'b000, 32'h40800000};
            {2'd1, 32'h40400000, 32'h3f800000}: alu_f = {3'b000, 32'h40000000};
            {2'd2, 32'h40000000, 32'h40400000}: alu_f = {3'b000, 32'h40c00000};
            {2'd2, 32'h7f7fffff, 32'h40000000}: alu_f = {3'b010, 32'h7f800000};
            default:                            alu_f = {3'b100, 32'hffffffff};
        endcase
    endfunction

    logic [34:0] ap [AS];
    logic [1:0]  aop [AS];
    logic [34:0] mp [MS];
    initial begin
        for (int i = 0; i < AS; i++) begin ap[i] = '0; aop[i] = '0; end
        for (int i = 0; i < MS; i++) mp[i] = '0;
    end
    always @(posedge clk) begin
        ap[0]  <= alu_f(alu_operation, alu_operand_a, alu_operand_b);
        aop[0] <= alu_operation;
        mp[0]  <= alu_f(alu_operation, alu_operand_a, alu_operand_b);
        for (int i = 1; i < AS; i++) begin ap[i] <= ap[i-1]; aop[i] <= aop[i-1]; end
        for (int i = 1; i < MS; i++) mp[i] <= mp[i-1];
    end
    assign {alu_exception, alu_overflow, alu_underflow, alu_result} =
        (aop[AS-1] != 2'd2) ? ap[AS-1] : mp[MS-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        id;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [2:0]  fl;
    } rec_t;
    rec_t q[$];
    always @(negedge clk) begin
        if (!reset && rsp_valid) q.push_back('{cyc, rsp_id, rsp_tag, rsp_result, rsp_flags});
    end

    int total = 0;
    int bad = 0;

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    task automatic drain();
        int k = 0;
        while (busy && k < 40) begin step(); k++; end
        step();
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL drain_timeout: busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        total++; if (alu_operand_a !== 32'd0) begin bad++; $display("FAIL rst_opa: got %h want 0", alu_operand_a); end
        total++; if (alu_operand_b !== 32'd0) begin bad++; $display("FAIL rst_opb: got %h want 0", alu_operand_b); end
        total++; if (alu_operation !== 2'd0) begin bad++; $display("FAIL rst_op: got %0d want 0", alu_operation); end
        total++; if ({rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags} !== '0) begin bad++; $display("FAIL rst_rsp: got %b/%h want 0", rsp_valid, rsp_result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_add();
        int acc;
        q.delete();
        set0(1, 2'd0, 32'h3f800000, 32'h40000000, 4'd5); #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", req0_ready); end
        acc = cyc + 1;
        step();
        set0(0, 2'd0, 0, 0, 0);
        total++; if ({alu_operand_a, alu_operand_b, alu_operation} !== {32'h3f800000, 32'h40000000, 2'd0}) begin
            bad++; $display("FAIL add_alu_in: got %h %h %0d want 3f800000 40000000 0", alu_operand_a, alu_operand_b, alu_operation); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy: got %b want 1", busy); end
        drain();
        total++; if (q.size() !== 1) begin bad++; $display("FAIL add_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            total++; if (q[0].c !== acc + 3) begin bad++; $display("FAIL add_lat: got %0d want %0d", q[0].c, acc + 3); end
            total++; if ({q[0].res, q[0].id, q[0].tag, q[0].fl} !== {32'h40400000, 1'b0, 4'd5, 3'b000}) begin
                bad++; $display("FAIL add_rsp: got %h id%0d tag%0d fl%b want 40400000 id0 tag5 fl000", q[0].res, q[0].id, q[0].tag, q[0].fl); end
        end
    endtask

    task automatic test_sub_mul();
        int a1, a2;
        q.delete();
        set1(1, 2'd1, 32'h40400000, 32'h3f800000, 4'd2); #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL sub_ready: got %b want 1", req1_ready); end
        a1 = cyc + 1;
        step();
        set1(1, 2'd2, 32'h40000000, 32'h40400000, 4'd3); #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mul_ready: got %b want 1", req1_ready); end
        a2 = cyc + 1;
        step();
        set1(0, 2'd0, 0, 0, 0);
        drain();
        total++; if (q.size() !== 2) begin bad++; $display("FAIL submul_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            total++; if ({q[0].c, q[0].res, q[0].id, q[0].tag} !== {a1 + 3, 32'h40000000, 1'b1, 4'd2}) begin
                bad++; $display("FAIL sub_rsp: got c%0d %h id%0d tag%0d want c%0d 40000000 id1 tag2", q[0].c, q[0].res, q[0].id, q[0].tag, a1 + 3); end
            total++; if ({q[1].c, q[1].res, q[1].id, q[1].tag} !== {a2 + 4, 32'h40c00000, 1'b1, 4'd3}) begin
                bad++; $display("FAIL mul_rsp: got c%0d %h id%0d tag%0d want c%0d 40c00000 id1 tag3", q[1].c, q[1].res, q[1].id, q[1].tag, a2 + 4); end
        end
    endtask

    task automatic test_collision();
        int m, a;
        q.delete();
        set0(1, 2'd2, 32'h40000000, 32'h40400000, 4'd4); #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL col_mul_ready: got %b want 1", req0_ready); end
        m = cyc + 1;
        step();
        set0(0, 2'd0, 0, 0, 0);
        set1(1, 2'd0, 32'h3f800000, 32'h40000000, 4'd6); #1;
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL col_blocked: got %b want 0", req1_ready); end
        step(); #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL col_accept: got %b want 1", req1_ready); end
        a = cyc + 1;
        step();
        set1(0, 2'd0, 0, 0, 0);
        drain();
        total++; if (a !== m + 2) begin bad++; $display("FAIL col_accept_cycle: got %0d want %0d", a, m + 2); end
        total++; if (q.size() !== 2) begin bad++; $display("FAIL col_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            total++; if ({q[0].c, q[0].res, q[0].id} !== {m + 4, 32'h40c00000, 1'b0}) begin
                bad++; $display("FAIL col_mul_rsp: got c%0d %h id%0d want c%0d 40c00000 id0", q[0].c, q[0].res, q[0].id, m + 4); end
            total++; if ({q[1].c, q[1].res, q[1].id, q[1].tag} !== {m + 5, 32'h40400000, 1'b1, 4'd6}) begin
                bad++; $display("FAIL col_add_rsp: got c%0d %h id%0d want c%0d 40400000 id1", q[1].c, q[1].res, q[1].id, m + 5); end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        logic [31:0] exp_res;
        q.delete();
        first = 0;
        set0(1, 2'd0, 32'h3f800000, 32'h40000000, 4'd1);
        set1(1, 2'd0, 32'h40000000, 32'h40000000, 4'd2);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 0) first = cyc + 1;
            total++; if ({req0_ready, req1_ready} !== {(i % 2 == 0), (i % 2 == 1)}) begin
                bad++; $display("FAIL rr_grant%0d: got %b%b want %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
            step();
        end
        set0(0, 2'd0, 0, 0, 0);
        set1(0, 2'd0, 0, 0, 0);
        drain();
        total++; if (q.size() !== 6) begin bad++; $display("FAIL rr_count: got %0d want 6", q.size()); end
        if (q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                exp_res = (i % 2 == 1) ? 32'h40800000 : 32'h40400000;
                total++; if ({q[i].c, q[i].id, q[i].res} !== {first + 3 + i, (i % 2 == 1), exp_res}) begin
                    bad++; $display("FAIL rr_rsp%0d: got c%0d id%0d %h want c%0d id%0d %h", i, q[i].c, q[i].id, q[i].res, first + 3 + i, i % 2, exp_res); end
            end
        end
    endtask

    task automatic test_illegal();
        int acc;
        q.delete();
        set0(1, 2'd3, 32'h12345678, 32'h9abcdef0, 4'd9); #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL ill_ready: got %b want 1", req0_ready); end
        acc = cyc + 1;
        step();
        set0(0, 2'd0, 0, 0, 0);
        total++; if ({alu_operation, alu_operand_a} !== {2'd0, 32'h40000000}) begin
            bad++; $display("FAIL ill_alu_hold: got %0d %h want 0 40000000", alu_operation, alu_operand_a); end
        drain();
        total++; if (q.size() !== 1) begin bad++; $display("FAIL ill_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            total++; if ({q[0].c, q[0].res, q[0].fl, q[0].tag, q[0].id} !== {acc + 3, 32'd0, 3'b100, 4'd9, 1'b0}) begin
                bad++; $display("FAIL ill_rsp: got c%0d %h fl%b tag%0d want c%0d 0 fl100 tag9", q[0].c, q[0].res, q[0].fl, q[0].tag, acc + 3); end
        end
    endtask

    task automatic test_overflow();
        int acc;
        q.delete();
        set1(1, 2'd2, 32'h7f7fffff, 32'h40000000, 4'd7); #1;
        acc = cyc + 1;
        step();
        set1(0, 2'd0, 0, 0, 0);
        drain();
        total++; if (q.size() !== 1) begin bad++; $display("FAIL ovf_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            total++; if ({q[0].c, q[0].res, q[0].fl, q[0].tag} !== {acc + 4, 32'h7f800000, 3'b010, 4'd7}) begin
                bad++; $display("FAIL ovf_rsp: got c%0d %h fl%b tag%0d want c%0d 7f800000 fl010 tag7", q[0].c, q[0].res, q[0].fl, q[0].tag, acc + 4); end
        end
    endtask

    task automatic test_reset_midflight();
        int acc;
        q.delete();
        set0(1, 2'd0, 32'h3f800000, 32'h40000000, 4'd1);
        step();
        set0(0, 2'd0, 0, 0, 0);
        set1(1, 2'd0, 32'h40000000, 32'h40000000, 4'd2);
        step();
        set1(0, 2'd0, 0, 0, 0);
        set0(1, 2'd2, 32'h40000000, 32'h40400000, 4'd3);
        step();
        set0(0, 2'd0, 0, 0, 0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1'b1; #1;
        total++; if ({busy, rsp_valid, alu_operand_a, alu_operation} !== {1'b0, 1'b0, 32'd0, 2'd0}) begin
            bad++; $display("FAIL mid_rst_state: got busy%b v%b %h %0d want all 0", busy, rsp_valid, alu_operand_a, alu_operation); end
        step();
        reset = 1'b0;
        repeat (8) step();
        total++; if (q.size() !== 0) begin bad++; $display("FAIL mid_dropped: got %0d responses want 0", q.size()); end
        total++; if ({busy, alu_operand_a, alu_operand_b} !== {1'b0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL mid_after: got busy%b %h %h want 0", busy, alu_operand_a, alu_operand_b); end
        set1(1, 2'd0, 32'h40400000, 32'h3f800000, 4'hA); #1;
        acc = cyc + 1;
        step();
        set1(0, 2'd0, 0, 0, 0);
        drain();
        total++; if (q.size() !== 1) begin bad++; $display("FAIL post_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            total++; if ({q[0].c, q[0].res, q[0].id, q[0].tag} !== {acc + 3, 32'h40800000, 1'b1, 4'hA}) begin
                bad++; $display("FAIL post_rsp: got c%0d %h id%0d tag%0d want c%0d 40800000 id1 tag10", q[0].c, q[0].res, q[0].id, q[0].tag, acc + 3); end
        end
        set0(1, 2'd0, 32'h3f800000, 32'h40000000, 4'd1);
        set1(1, 2'd0, 32'h40000000, 32'h40000000, 4'd2); #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL post_rr0: got %b%b want 10", req0_ready, req1_ready); end
        step(); #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL post_rr1: got %b%b want 01", req0_ready, req1_ready); end
        step();
        set0(0, 2'd0, 0, 0, 0);
        set1(0, 2'd0, 0, 0, 0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_sub_mul();
        test_collision();
        test_back_to_back();
        test_illegal();
        test_overflow();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
Shares one Static_ALU instance between two requesters over valid/ready request channels. It arbitrates requests round-robin and drives the ALU operand and operation inputs. Because ADD/SUB and MUL have different static latencies, it holds a writeback-slot reservation so that no two results return in the same cycle. It tags each issued op and realigns the ALU result, flags, requester id and tag onto a single response port.

Parameters:
ADDER_STAGES, 2, pipeline depth of the ALU adder path (ops 0 and 1); must be at least 1 and must match the ALU instance.
MULT_STAGES, 3, pipeline depth of the ALU multiplier path (op 2); must be at least 1 and must match the ALU instance.
TAG_W, 4, width of the requester-supplied tag.
MAX_LAT (localparam), max(ADDER_STAGES, MULT_STAGES) + 1, depth of the reservation and tag pipeline.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
reqN_valid  in  1  request valid, N = 0 and 1
reqN_ready  out  1  request accepted this cycle (combinational)
reqN_op  in  2  operation: 0 = ADD, 1 = SUB, 2 = MUL, 3 = illegal
reqN_a, reqN_b  in  32  IEEE-754 single-precision operands
reqN_tag  in  TAG_W  opaque tag, returned unchanged on the response
alu_operand_a, alu_operand_b  out  32  registered ALU operand inputs
alu_operation  out  2  registered ALU operation input
alu_result  in  32  ALU result
alu_exception, alu_overflow, alu_underflow  in  1  ALU status flags
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester that issued the op
rsp_tag  out  TAG_W  tag of the op
rsp_result  out  32  result
rsp_flags  out  3  {exception, overflow, underflow}
busy  out  1  at least one op is in flight

Behaviour:
- Reset (async, active-high): all registered outputs go to 0 (alu_operand_a/b = 0, alu_operation = 0, rsp_* = 0, busy = 0). The reservation vector and tag pipeline clear. The round-robin pointer points to req0. Ops in flight at reset are dropped and never produce a response.
- Op latency L(op): ADDER_STAGES for ops 0, 1 and 3; MULT_STAGES for op 2.
- Handshake and latency: an op is accepted when reqN_valid && reqN_ready at a rising edge. That edge loads alu_* and reserves a slot. rsp_valid is high exactly L(op)+1 cycles after the accept edge, for exactly one cycle, with result and flags registered from the ALU. When no op is accepted, alu_* hold their previous values.
- Reservation: a MAX_LAT-bit vector res that shifts down by one every cycle. Requester N is eligible when reqN_valid is high and res[L(op)] is 0, evaluated after this cycle's shift. Accepting an op sets res[L(op)]. This guarantees at most one return per cycle.
- Arbitration: at most one accept per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester indicated by the pointer is granted.
  - After any grant, the pointer moves to the other requester.
  - The loser's reqN_ready is 0.
  - reqN_ready depends combinationally on valid and op; requesters must not make valid depend on ready.
- Request stability: a request may not be withdrawn and its fields may not change while valid is high and ready is low.
- Illegal op (3): accepted normally and reserves a slot at ADDER_STAGES, but the ALU is not driven; alu_* hold their values. The response returns rsp_result = 0 and rsp_flags = 3'b100.
- Tag pipeline: {id, tag, illegal} entries travel alongside the reservation and are read out on the return cycle.
- busy = |res.
- Back-to-back ops of equal latency: one accept per cycle, responses one per cycle in issue order.

Test Plan:
1. ADDER_STAGES=2, MULT_STAGES=3. req0 ADD a=3f800000, b=40000000, tag=5 → rsp_valid exactly 3 cycles after accept; rsp_result=40400000, rsp_id=0, rsp_tag=5, rsp_flags=000.
2. req1 SUB 40400000 − 3f800000, tag=2, followed by req1 MUL 40000000 × 40400000, tag=3 → results 40000000 then 40c00000, in order, each at its specified latency, tags 2 then 3.
3. Collision: MUL accepted at cycle 0; ADD valid from cycle 1 → req ready is 0 at cycle 1 and the ADD is accepted at cycle 2. rsp_valid fires at cycles 4 (MUL) and 5 (ADD); never two returns in one cycle.
4. Both requesters hold ADD valid for 6 cycles → grants alternate 0,1,0,1,0,1. rsp_valid is high 6 consecutive cycles with rsp_id alternating.
5. Illegal op: req0 op=3, tag=9 → alu_operation unchanged; rsp 3 cycles later with rsp_result=0, rsp_flags=100, rsp_tag=9.
6. Accept 3 ops, then pulse reset for 1 cycle mid-flight → no rsp_valid afterwards, busy=0, alu_* = 0. A new req1-only ADD then completes normally, and when both requesters are next valid, req0 wins first.
